// File: rtl/vga_pixel_fetch.sv
// Framebuffer line prefetch into a ping-pong buffer, 2x upscale and centring for VGA output.
// Define VGA_FETCH_TESTPAT_EN to add a testpat input that replaces the image with 8 colour bars.
module vga_pixel_fetch #(
  parameter int DISP_W = 1280,
  parameter int DISP_H = 1024,
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480,
  parameter int X_OFF  = 0,
  parameter int Y_OFF  = 32,
  parameter int ADDR_W = 19
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic [$clog2(DISP_W):0] x,
  input  logic [$clog2(DISP_H):0] y,
  input  logic                    active,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
`ifdef VGA_FETCH_TESTPAT_EN
  input  logic                    testpat,
`endif
  output logic                    rd_req,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_gnt,
  input  logic                    rd_valid,
  input  logic [15:0]             rd_data,
  output logic [3:0]              r,
  output logic [3:0]              g,
  output logic [3:0]              b,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    underrun
);

  localparam int SXW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int CW  = $clog2(SRC_W + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic              disp_sel_q, disp_sel_d;
  logic              underrun_q, underrun_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     iss_q, iss_d;
  logic [CW-1:0]     ret_q, ret_d;

  logic [SXW-1:0]    sx_q, sx_d;
  logic              win_q, win_d;
  logic              hs1_q, vs1_q;
  logic              tp_q, tp_d;
  logic [2:0]        bar_q, bar_d;
  logic [11:0]       rgb_q, rgb_d;
  logic              hs2_q, vs2_q;

  logic [15:0]       mem [2][SRC_W];
  logic [15:0]       pix;
  logic              tp;
  logic [31:0]       xo, yo;
  logic              at_x0, pre_trig, swap_trig, more_lines;
  logic              beat, grant;
  logic [2:0]        bar_c;
  logic              unused_pix;

`ifdef VGA_FETCH_TESTPAT_EN
  assign tp = testpat;
`else
  assign tp = 1'b0;
`endif

  // Offsets wrap to huge values left of / above the image, so one compare bounds both sides.
  assign xo = 32'(x) - 32'(X_OFF);
  assign yo = 32'(y) - 32'(Y_OFF);

  assign at_x0      = (x == '0) && !tp;
  assign pre_trig   = at_x0 && (32'(y) == 32'(DISP_H));
  assign swap_trig  = at_x0 && (yo < 32'(2 * SRC_H)) && !yo[0];
  assign more_lines = (yo != 32'(2 * (SRC_H - 1)));

  assign beat  = rd_valid && (state_q != StIdle) && (ret_q < CW'(SRC_W));
  assign grant = rd_req_q && rd_gnt;

  always_comb begin
    state_d    = state_q;
    disp_sel_d = disp_sel_q;
    underrun_d = underrun_q;
    rd_req_d   = rd_req_q;
    rd_addr_d  = rd_addr_q;
    base_d     = base_q;
    iss_d      = iss_q;
    ret_d      = ret_q;

    if (beat) ret_d = ret_q + CW'(1);

    case (state_q)
      StIssue: begin
        if (grant) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          iss_d     = iss_q + CW'(1);
          if (iss_q == CW'(SRC_W - 1)) begin
            rd_req_d = 1'b0;
            state_d  = (ret_d == CW'(SRC_W)) ? StIdle : StDrain;
          end
        end
      end
      StDrain: if (ret_d == CW'(SRC_W)) state_d = StIdle;
      default: ;
    endcase

    // A late trigger still swaps; the in-flight fetch is left to finish.
    if (pre_trig || swap_trig) begin
      if (state_q != StIdle) underrun_d = 1'b1;
      if (swap_trig) disp_sel_d = !disp_sel_q;
      base_d = pre_trig ? '0 : base_q + ADDR_W'(SRC_W);
      if ((state_q == StIdle) && (pre_trig || more_lines)) begin
        state_d   = StIssue;
        rd_req_d  = 1'b1;
        rd_addr_d = base_d;
        iss_d     = '0;
        ret_d     = '0;
      end
    end
  end

  always_comb begin
    win_d = active && (xo < 32'(2 * SRC_W)) && (yo < 32'(2 * SRC_H));
    sx_d  = xo[SXW:1];
    tp_d  = tp;
`ifdef VGA_FETCH_TESTPAT_EN
    bar_d = 3'(xo / 32'(SRC_W / 4));
`else
    bar_d = 3'd0;
`endif
  end

  assign pix        = mem[disp_sel_q][sx_q];
  assign unused_pix = ^{pix[11], pix[6:5], pix[0]};

  always_comb begin
    case (bar_q)
      3'd0:    bar_c = 3'b111;
      3'd1:    bar_c = 3'b110;
      3'd2:    bar_c = 3'b011;
      3'd3:    bar_c = 3'b010;
      3'd4:    bar_c = 3'b101;
      3'd5:    bar_c = 3'b100;
      3'd6:    bar_c = 3'b001;
      default: bar_c = 3'b000;
    endcase
    rgb_d = '0;
    if (win_q) begin
      if (tp_q) rgb_d = {{4{bar_c[2]}}, {4{bar_c[1]}}, {4{bar_c[0]}}};
      else      rgb_d = {pix[15:12], pix[10:7], pix[4:1]};
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      disp_sel_q <= 1'b0;
      underrun_q <= 1'b0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      base_q     <= '0;
      iss_q      <= '0;
      ret_q      <= '0;
      sx_q       <= '0;
      win_q      <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      tp_q       <= 1'b0;
      bar_q      <= '0;
      rgb_q      <= '0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      disp_sel_q <= disp_sel_d;
      underrun_q <= underrun_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      base_q     <= base_d;
      iss_q      <= iss_d;
      ret_q      <= ret_d;
      sx_q       <= sx_d;
      win_q      <= win_d;
      hs1_q      <= hsync_in;
      vs1_q      <= vsync_in;
      tp_q       <= tp_d;
      bar_q      <= bar_d;
      rgb_q      <= rgb_d;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
    end
  end

  // Line buffer is deliberately not reset.
  always_ff @(posedge pclk) begin
    if (beat) mem[!disp_sel_q][ret_q[SXW-1:0]] <= rd_data;
  end

  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign underrun  = underrun_q;
  assign r         = rgb_q[11:8];
  assign g         = rgb_q[7:4];
  assign b         = rgb_q[3:0];
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

endmodule
